key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Parametrised N-channel synthesizable front end for the board push-buttons (keys_i) feeding the pong game logic.
- Per channel it performs:
  - two-flop synchronisation;
  - optional polarity inversion;
  - counter-based debounce;
  - press/release edge pulses;
  - optional auto-repeat of the press pulse while a key is held.
- Replaces the raw key usage in the board top, so paddle control sees clean, single-cycle events.

Parameters:
- N_KEYS, 3, number of key channels.
- ACTIVE_LOW, 1, 1 = a raw key reads 0 when pressed; the block inverts so that internally 1 = pressed.
- DEBOUNCE_CYCLES, 270_000, number of consecutive synced samples at the new level required to accept a change (≥1).
- REPEAT_EN, 1, 0 disables auto-repeat entirely.
- REPEAT_DELAY, 13_500_000, cycles from the initial press pulse to the first repeat pulse (≥1).
- REPEAT_PERIOD, 2_700_000, cycles between subsequent repeat pulses (≥1).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous active-high reset.
- keys_i  input  N_KEYS  raw asynchronous key levels.
- pressed_o  output  N_KEYS  debounced level, 1 = held.
- press_o  output  N_KEYS  1-cycle pulse on accepted press and on every auto-repeat.
- release_o  output  N_KEYS  1-cycle pulse on accepted release.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - sync flops, debounce and repeat counters cleared;
  - stable state = released;
  - pressed_o, press_o, release_o = 0 from the next cycle.
  - Reset asserted mid-operation aborts any count with no pulses.
  - A key held through reset is treated as a new press: it is accepted after the normal latency and emits press_o.
- Synchroniser: raw key, after polarity correction, passes through 2 flops to give "synced".
- Debounce, per channel, with counter width $clog2(DEBOUNCE_CYCLES+1):
  - synced == stable → counter cleared.
  - synced != stable → counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and synced still differs: stable toggles and the counter clears in that same edge.
- Latency: a clean level change sampled at edge 0 appears on pressed_o after edge 2+DEBOUNCE_CYCLES.
- Glitch rejection: a glitch shorter than DEBOUNCE_CYCLES synced cycles is fully rejected, because the counter clears on any return to stable.
- Edge pulses:
  - press_o is high for exactly the cycle in which pressed_o first reads 1.
  - release_o is high for exactly the cycle in which pressed_o first reads 0.
  - All outputs are registered.
- Per-channel state machine: RELEASED → (accepted press) HELD_DELAY → (repeat count expires) HELD_REPEAT; any accepted release → RELEASED.
- Repeat counter, width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1):
  - loaded with REPEAT_DELAY on entry to HELD_DELAY;
  - on expiry, pulses press_o and reloads with REPEAT_PERIOD.
  - Repeat pulses therefore occur REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles.
- REPEAT_EN = 0: the repeat counter is idle and only one press_o per press is produced.
- Simultaneous events:
  - Channels are fully independent; several channels may pulse in the same cycle.
  - A release accepted in the same cycle a repeat would expire: release_o is asserted, press_o is not.
- Illegal parameters (any of DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD below 1) are rejected at elaboration.

Decomposition:
- Package pong_pkg holds:
  - default timing constants for the 27 MHz board clock (DEBOUNCE_10MS, REPEAT_500MS, REPEAT_100MS);
  - the channel FSM state enum key_state_t {RELEASED, HELD_DELAY, HELD_REPEAT}.
- Sub-module key_debounce_channel contains one channel: synchroniser, debounce counter, FSM and repeat counter.
- key_conditioner instantiates N_KEYS channels in a generate loop and only fans the ports in and out.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, N_KEYS=3, ACTIVE_LOW=1):
1. Reset release with all keys_i=3'b111 → all outputs 0 for 50 cycles, with no pulses.
2. keys_i[0] driven to 0 at edge 0 and held → pressed_o[0]=1 from edge 6, with press_o[0] high for only that cycle.
3. Continue holding key 0 → press_o[0] repeat pulses at edges 16, 21, 26 …; pressed_o[0] stays 1.
4. Release key 0 at edge 30 → pressed_o[0]=0 and release_o[0] 1-cycle pulse at edge 36; no further press_o.
5. keys_i[1] glitch low for 3 cycles, then high → pressed_o[1], press_o[1], release_o[1] stay 0 throughout.
6. Keys 1 and 2 pressed in the same cycle, then rst_i asserted for 1 cycle at edge 4 → no pulses; after reset both are accepted 6 edges after reset deassertion, with press_o[1] and press_o[2] in the same cycle.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong board front end.
// Timing defaults assume the 27 MHz board clock.
package pong_pkg;

  localparam int DEBOUNCE_10MS = 270_000;
  localparam int REPEAT_500MS  = 13_500_000;
  localparam int REPEAT_100MS  = 2_700_000;

  typedef enum logic [1:0] {
    RELEASED,
    HELD_DELAY,
    HELD_REPEAT
  } key_state_t;

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: two-flop synchroniser, debounce counter, held-state FSM
// and auto-repeat counter, with registered level and pulse outputs.
module key_debounce_channel
  import pong_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = REPEAT_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("key_debounce_channel: timing parameters must be >= 1");
  end

  logic             key_corr;
  logic [1:0]       sync_d, sync_q;
  logic [DB_W-1:0]  cnt_d, cnt_q;
  logic             stable_d, stable_q;
  logic [REP_W-1:0] rep_d, rep_q;
  key_state_t       state_d, state_q;
  logic             pressed_d, pressed_q;
  logic             press_d, press_q;
  logic             release_d, release_q;
  logic             press_evt, release_evt, fire;

  assign key_corr = (ACTIVE_LOW != 0) ? ~key_i : key_i;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sync_d   = {sync_q[0], key_corr};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    // The counter restarts on any return to the stable level, so short glitches vanish.
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  // Accepted edges are seen one cycle after stable changes, aligned with pressed_q.
  assign press_evt   = stable_q & ~pressed_q;
  assign release_evt = ~stable_q & pressed_q;

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    fire    = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (press_evt) begin
          state_d = HELD_DELAY;
          rep_d   = (REPEAT_EN != 0) ? REP_W'(REPEAT_DELAY) : '0;
        end
      end
      HELD_DELAY, HELD_REPEAT: begin
        // A release wins over a repeat expiring in the same cycle.
        if (release_evt) begin
          state_d = RELEASED;
          rep_d   = '0;
        end else if (REPEAT_EN != 0 && rep_q == REP_W'(1)) begin
          fire    = 1'b1;
          state_d = HELD_REPEAT;
          rep_d   = REP_W'(REPEAT_PERIOD);
        end else if (rep_q != '0) begin
          rep_d = rep_q - REP_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        rep_d   = '0;
      end
    endcase
  end

  assign pressed_d = stable_q;
  assign press_d   = press_evt | fire;
  assign release_d = release_evt;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      rep_q     <= '0;
      state_q   <= RELEASED;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      rep_q     <= rep_d;
      state_q   <= state_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign pressed_o = pressed_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// N-channel push-button conditioner: fans keys out to independent
// debounce/auto-repeat channels and gathers their outputs.
module key_conditioner
  import pong_pkg::*;
#(
  parameter int N_KEYS          = 3,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = REPEAT_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_KEYS-1:0] keys_i,
  output logic [N_KEYS-1:0] pressed_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .key_i     (keys_i[i]),
      .pressed_o (pressed_o[i]),
      .press_o   (press_o[i]),
      .release_o (release_o[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with short debounce/repeat timing.
// Expected output vectors are queued per edge and compared just after that edge.
module tb_key_conditioner;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [2:0] keys_i = 3'b111;
  logic [2:0] pressed_o, press_o, release_o;

  logic [8:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  key_conditioner #(
    .N_KEYS          (3),
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .keys_i    (keys_i),
    .pressed_o (pressed_o),
    .press_o   (press_o),
    .release_o (release_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Key 0 scenario timeline: press sampled at edge 0, release sampled at edge 30.
  function automatic logic [8:0] key0_exp(input int e);
    logic p, pr, r;
    p  = (e >= 6) && (e < 36);
    pr = (e == 6) || (e == 16) || (e == 21) || (e == 26) || (e == 31);
    r  = (e == 36);
    return {2'b00, p, 2'b00, pr, 2'b00, r};
  endfunction

  task automatic test_reset();
    logic [8:0] got, exp;
    keys_i = 3'b111;
    for (int e = 0; e < 53; e++) begin
      rst_i = (e < 3);
      exp_q.push_back(9'b0);
      step();
      got = {pressed_o, press_o, release_o};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset edge %0d got %b expected %b", e, got, exp);
      end
    end
  endtask

  task automatic test_press();
    logic [8:0] got, exp;
    for (int e = 0; e < 16; e++) begin
      keys_i = 3'b110;
      exp_q.push_back(key0_exp(e));
      step();
      got = {pressed_o, press_o, release_o};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL press edge %0d got %b expected %b", e, got, exp);
      end
    end
  endtask

  task automatic test_repeat();
    logic [8:0] got, exp;
    for (int e = 16; e < 30; e++) begin
      keys_i = 3'b110;
      exp_q.push_back(key0_exp(e));
      step();
      got = {pressed_o, press_o, release_o};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL repeat edge %0d got %b expected %b", e, got, exp);
      end
    end
  endtask

  // Edge 36 is also where the next repeat would expire; release must win.
  task automatic test_release();
    logic [8:0] got, exp;
    for (int e = 30; e < 50; e++) begin
      keys_i = 3'b111;
      exp_q.push_back(key0_exp(e));
      step();
      got = {pressed_o, press_o, release_o};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL release edge %0d got %b expected %b", e, got, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [8:0] got, exp;
    for (int e = 0; e < 25; e++) begin
      keys_i = (e < 3) ? 3'b101 : 3'b111;
      exp_q.push_back(9'b0);
      step();
      got = {pressed_o, press_o, release_o};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL glitch edge %0d got %b expected %b", e, got, exp);
      end
    end
  endtask

  // Keys 1 and 2 pressed together; a 1-cycle reset at edge 4 aborts the count,
  // then both re-qualify from edge 5 and press at edge 11, repeating at edge 21.
  task automatic test_reset_abort();
    logic [8:0] got, exp;
    logic [2:0] p, pr;
    for (int e = 0; e < 23; e++) begin
      keys_i = 3'b001;
      rst_i  = (e == 4);
      p  = (e >= 11) ? 3'b110 : 3'b000;
      pr = (e == 11 || e == 21) ? 3'b110 : 3'b000;
      exp_q.push_back({p, pr, 3'b000});
      step();
      got = {pressed_o, press_o, release_o};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_abort edge %0d got %b expected %b", e, got, exp);
      end
    end
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_repeat();
    test_release();
    test_glitch();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
